scc_fetch_unit: RTL and testbench

Instruction fetch stage of the SCC core. It sits directly upstream of the unified instruction/data memory. It owns the program counter, drives the memory's instruction-port enable and address, and captures each returned 32-bit big-endian word into a one-entry output register. That register feeds decode through a valid/ready handshake. It also handles branch redirects and the program halt sequence; dropping the instruction enable at halt triggers the simulation memory dump.

---
 rtl/scc_fetch_unit.sv | 111 +++++++++++
 tb/tb_scc_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scc_fetch_unit.sv
// scc_fetch_unit: instruction fetch stage of the SCC core.
// Owns the PC and drives the instruction-port enable and address of the unified memory.
// Each returned word is captured into a one-entry register that feeds decode through valid/ready.
// Also handles branch redirects and the halt sequence (en falls once the halt word is consumed).
module scc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] HALT_INSN = 32'hF8000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    output logic        instruction_memory_en,
    output logic [31:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_v,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        misalign_err,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;

    // Held output register presented to decode
    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] pc;
    } if_reg_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    if_reg_t     out_q;
    logic        misalign_q;
    logic        redirect, capture, consume;

    // Enable is a pure decode of state, so it only changes on IDLE->FETCH and DRAIN->HALTED
    assign instruction_memory_en = (state_q == FETCH) || (state_q == DRAIN);
    assign instruction_memory_a  = pc_q;
    assign halted                = (state_q == HALTED);
    assign if_valid              = out_q.valid;
    assign if_instruction        = out_q.insn;
    assign if_pc                 = out_q.pc;
    assign misalign_err          = misalign_q;

    // A branch outranks capture, stall, consume and halt whenever fetch is active
    assign redirect = branch_taken && ((state_q == FETCH) || (state_q == DRAIN));

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and capture/consume decode
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        consume = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (!redirect) begin
                    // Load when the register is empty or being emptied this cycle
                    capture = !out_q.valid || if_ready;
                    if (capture && (instruction_memory_v == HALT_INSN)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (out_q.valid && if_ready) begin
                    consume = 1'b1;
                    state_d = HALTED;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // PC, output register and misalign pulse
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            out_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if ((state_q == IDLE) && start) pc_q <= RESET_PC;
            if (redirect) begin
                // Target is forced word-aligned; the younger held instruction is flushed
                pc_q        <= {branch_target[31:2], 2'b00};
                out_q.valid <= 1'b0;
                misalign_q  <= |branch_target[1:0];
            end else if (capture) begin
                out_q.valid <= 1'b1;
                out_q.insn  <= instruction_memory_v;
                out_q.pc    <= pc_q;
                pc_q        <= pc_q + 32'd4;
            end else if (consume) begin
                out_q.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scc_fetch_unit.sv
// Directed self-checking bench for scc_fetch_unit with a combinational memory model.
module tb_scc_fetch_unit;

    localparam logic [31:0] HALT = 32'hF8000000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_a;
    logic [31:0] instruction_memory_v;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        misalign_err;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:127];

    scc_fetch_unit dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .start                 (start),
        .instruction_memory_en (instruction_memory_en),
        .instruction_memory_a  (instruction_memory_a),
        .instruction_memory_v  (instruction_memory_v),
        .branch_taken          (branch_taken),
        .branch_target         (branch_target),
        .if_ready              (if_ready),
        .if_valid              (if_valid),
        .if_instruction        (if_instruction),
        .if_pc                 (if_pc),
        .misalign_err          (misalign_err),
        .halted                (halted)
    );

    always #5 Clk = ~Clk;

    // Memory returns the word at the driven address in the same cycle
    assign instruction_memory_v = mem[instruction_memory_a[8:2]];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step();
        step();
        chk("rst_en", {31'd0, instruction_memory_en}, 32'd0);
        chk("rst_a", instruction_memory_a, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_insn", if_instruction, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        // branch ignored in IDLE
        Reset = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        chk("idle_br_en", {31'd0, instruction_memory_en}, 32'd0);
        chk("idle_br_a", instruction_memory_a, 32'd0);
    endtask

    task automatic test_fetch_stall();
        if_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("c1_en", {31'd0, instruction_memory_en}, 32'd1);
        chk("c1_a", instruction_memory_a, 32'd0);
        chk("c1_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("c2_valid", {31'd0, if_valid}, 32'd1);
        chk("c2_pc", if_pc, 32'd0);
        chk("c2_insn", if_instruction, 32'h11111111);
        chk("c2_a", instruction_memory_a, 32'd4);
        step();
        chk("c3_pc", if_pc, 32'd4);
        chk("c3_insn", if_instruction, 32'h22222222);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", if_pc, 32'd4);
            chk("stall_insn", if_instruction, 32'h22222222);
            chk("stall_a", instruction_memory_a, 32'd8);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        if_ready = 1'b1;
        step();
        chk("rel_pc", if_pc, 32'd8);
        chk("rel_insn", if_instruction, 32'h33333333);
        chk("rel_a", instruction_memory_a, 32'hC);
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("br_valid", {31'd0, if_valid}, 32'd0);
        chk("br_a", instruction_memory_a, 32'h100);
        chk("br_mis", {31'd0, misalign_err}, 32'd0);
        step();
        chk("br2_valid", {31'd0, if_valid}, 32'd1);
        chk("br2_pc", if_pc, 32'h100);
        chk("br2_insn", if_instruction, 32'hA0000100);
        // misaligned target
        branch_taken = 1'b1;
        branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
        chk("mis_a", instruction_memory_a, 32'h100);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);
        chk("mis_pc", if_pc, 32'h100);
        chk("mis_insn", if_instruction, 32'hA0000100);
    endtask

    task automatic test_halt();
        branch_taken = 1'b1;
        branch_target = 32'h8;
        step();
        branch_taken = 1'b0;
        chk("h_a", instruction_memory_a, 32'h8);
        step();
        chk("h_pc8", if_pc, 32'h8);
        step();
        chk("h_pcC", if_pc, 32'hC);
        chk("h_insn", if_instruction, HALT);
        if_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("drain_valid", {31'd0, if_valid}, 32'd1);
            chk("drain_insn", if_instruction, HALT);
            chk("drain_en", {31'd0, instruction_memory_en}, 32'd1);
            chk("drain_halted", {31'd0, halted}, 32'd0);
            chk("drain_a", instruction_memory_a, 32'h10);
        end
        if_ready = 1'b1;
        step();
        chk("hlt_en", {31'd0, instruction_memory_en}, 32'd0);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_valid", {31'd0, if_valid}, 32'd0);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_halted", {31'd0, halted}, 32'd1);
            chk("hold_en", {31'd0, instruction_memory_en}, 32'd0);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        if_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("ms_valid", {31'd0, if_valid}, 32'd1);
        chk("ms_pc", if_pc, 32'd0);
        Reset = 1'b0;
        step();
        chk("mr_en", {31'd0, instruction_memory_en}, 32'd0);
        chk("mr_a", instruction_memory_a, 32'd0);
        chk("mr_valid", {31'd0, if_valid}, 32'd0);
        chk("mr_insn", if_instruction, 32'd0);
        chk("mr_pc", if_pc, 32'd0);
        chk("mr_halted", {31'd0, halted}, 32'd0);
        Reset = 1'b1;
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_en", {31'd0, instruction_memory_en}, 32'd0);
            chk("idle_valid", {31'd0, if_valid}, 32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rs_en", {31'd0, instruction_memory_en}, 32'd1);
        chk("rs_a", instruction_memory_a, 32'd0);
        step();
        chk("rs_valid", {31'd0, if_valid}, 32'd1);
        chk("rs_insn", if_instruction, 32'h11111111);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA0000000 | (i * 4);
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = HALT;
        test_reset();
        test_fetch_stall();
        test_branch();
        test_halt();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
